led_request_arbiter: RTL

//  Shares the 4-LED bank between up to 4 requesters (e.g. over-temp alarm, sensor fault, tx done).

---
 rtl/led_request_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/led_request_arbiter.sv
// led_request_arbiter: shares the 4-LED bank between up to 4 requesters.
// Pending requests are served round-robin, one grant at a time. Each grant
// drives a steady or blinking pattern for a fixed hold time and is followed
// by a mandatory dark gap.
module led_request_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int BLINK_HALF  = 12_500_000,
  parameter int GAP_CYCLES  = 10_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_mode,
  input  logic            abort,
  output logic [3:0]      led_on,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            done,
  output logic [1:0]      done_id
);

  // Reject illegal parameter values at elaboration.
  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("led_request_arbiter: NREQ must be 2..4");
  end
  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("led_request_arbiter: HOLD_CYCLES must be >= 2");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink
    $error("led_request_arbiter: BLINK_HALF must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("led_request_arbiter: GAP_CYCLES must be >= 1");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // All terminal-count compares are done at the full 32-bit counter width.
  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] BLINK_DIV  = 32'(BLINK_HALF);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);
  localparam logic [1:0]  RR_INIT    = 2'(NREQ - 1);

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [31:0]     count_q, count_d;
  logic            phase_q, phase_d;
  logic [1:0]      rr_last_q, rr_last_d;
  logic [1:0]      owner_q, owner_d;
  logic            mode_q, mode_d;
  logic            done_q, done_d;
  logic [1:0]      done_id_q, done_id_d;

  // Zero-extended views so a 2-bit index is always in range for any NREQ.
  logic [3:0]      pend4, mode4;
  logic            pick_valid;
  logic [1:0]      pick;
  logic [NREQ-1:0] pick_onehot;

  assign pend4       = 4'(pending_q);
  assign mode4       = 4'(req_mode);
  assign pick_onehot = NREQ'(1) << pick;

  // Round-robin pick: first pending bit scanning upward from rr_last+1.
  always_comb begin
    pick_valid = 1'b0;
    pick       = rr_last_q;
    for (int k = 1; k <= NREQ; k++) begin
      logic [1:0] idx;
      idx = 2'((int'(rr_last_q) + k) % NREQ);
      if (!pick_valid && pend4[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

  // Next-state logic for the IDLE/ON/GAP sequencer; abort overrides all.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | req;
    grant_d   = grant_q;
    count_d   = count_q;
    phase_d   = phase_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d   = S_ON;
          grant_d   = pick_onehot;
          rr_last_d = pick;
          owner_d   = pick;
          mode_d    = mode4[pick];
          // A fresh req from the picked requester in this same cycle re-queues it.
          pending_d = (pending_q & ~pick_onehot) | req;
          count_d   = '0;
          phase_d   = 1'b1;
        end
      end
      S_ON: begin
        count_d = count_q + 32'd1;
        if ((count_q % BLINK_DIV) == BLINK_LAST) phase_d = ~phase_q;
        if (count_q == HOLD_LAST) begin
          state_d   = S_GAP;
          count_d   = '0;
          grant_d   = '0;
          done_d    = 1'b1;
          done_id_d = owner_q;
        end
      end
      S_GAP: begin
        count_d = count_q + 32'd1;
        if (count_q == GAP_LAST) begin
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
        grant_d = '0;
      end
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      pending_d = '0;
      grant_d   = '0;
      count_d   = '0;
      phase_d   = 1'b0;
      done_d    = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      count_q   <= '0;
      phase_q   <= 1'b0;
      rr_last_q <= RR_INIT;
      owner_q   <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      count_q   <= count_d;
      phase_q   <= phase_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  // LED decode straight from registered state: no extra latency.
  always_comb begin
    led_on = 4'h0;
    if (state_q == S_ON) begin
      if (mode_q) led_on = phase_q ? 4'hF : 4'h0;
      else        led_on = 4'b0001 << owner_q;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule
